fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BOOT_CYCLES, default 2: post-reset cycles before the first fetch.
REQ-002 Parameter FLUSH_CYCLES, default 1: extra bubble cycles after a redirect (0 = redirect cycle only).
REQ-003 Ports: clk in 1 (system clock); rst in 1 (reset, asynchronous, active-high).
REQ-004 stall in 1: decode hazard, hold PC and fetch register.
REQ-005 imem_ready in 1: instruction memory data valid this cycle.
REQ-006 jump_req, jr_req, branch_taken in 1 each: redirect to absolute address, to Rs, or to branch target.
REQ-007 halt in 1: halt instruction decoded; resume in 1: leave halt.
REQ-008 next_sel out 2: fetch mux select, 0=PC+4, 1=address, 2=Rs, 3=Branch.
REQ-009 pc_we out 1; ifreg_we out 1; ifreg_flush out 1 (load NOP into fetch register); fetch_valid out 1 (=ifreg_we & ~ifreg_flush).
REQ-010 state out 3: current FSM state; instr_count out 32; bubble_count out 32.

Function
REQ-011 States: BOOT, RUN, WAIT_MEM, FLUSH, HALTED; state registered, outputs Mealy from state and inputs.
REQ-012 Redirect priority: branch_taken > jr_req > jump_req; next_sel = 3/2/1 respectively, otherwise 0.
REQ-013 Default (no rule applies): pc_we=0, ifreg_we=0, ifreg_flush=0, next_sel=0.
REQ-014 BOOT: pc_we=0, ifreg_we=1, ifreg_flush=1; all requests ignored; after BOOT_CYCLES cycles go RUN.
REQ-015 RUN priority: redirect > stall > halt > ~imem_ready > normal.
REQ-016 RUN redirect: pc_we=1, selected next_sel, ifreg_we=1, ifreg_flush=1; go FLUSH if FLUSH_CYCLES>0, else stay RUN.
REQ-017 RUN stall: pc_we=0, ifreg_we=0; stay RUN.
REQ-018 RUN halt: pc_we=0, ifreg_we=1, ifreg_flush=1; go HALTED.
REQ-019 RUN ~imem_ready: pc_we=0, ifreg_we=1, ifreg_flush=1; go WAIT_MEM.
REQ-020 RUN normal: pc_we=1, next_sel=0, ifreg_we=1, fetch_valid=1.
REQ-021 WAIT_MEM: bubble outputs per REQ-019; redirect takes PC (pc_we=1, next_sel) but stays WAIT_MEM; imem_ready=1 moves to RUN next cycle, current cycle remains a bubble.
REQ-022 FLUSH: pc_we=0, ifreg_we=1, ifreg_flush=1 for FLUSH_CYCLES cycles, then RUN; a redirect in FLUSH reloads the counter and takes the new target.
REQ-023 HALTED: bubble outputs; redirect and stall ignored; resume=1 moves to RUN next cycle.
REQ-024 instr_count increments on each fetch_valid cycle; bubble_count on each ifreg_flush cycle outside BOOT; both saturate at 0xFFFFFFFF.

Reset
REQ-025 rst=1 forces state=BOOT, boot counter=BOOT_CYCLES, flush counter=0, both counters=0, immediately and regardless of clk.
REQ-026 During rst: pc_we=0, ifreg_we=1, ifreg_flush=1, fetch_valid=0, next_sel=0.
REQ-027 Reset asserted mid-redirect, mid-flush or in HALTED discards all pending state; behaviour resumes per REQ-014.

Structure
REQ-028 Shared package fetch_pkg holds the state enum, next_sel constants SEL_PC4/SEL_ADDR/SEL_RS/SEL_BRANCH, and the counter width.
REQ-029 One sub-module, sat_counter32 (enable, async clear, saturating), instantiated twice for the counters.

Verification
REQ-030 Reset, then idle with imem_ready=1 -> BOOT for 2 cycles, then pc_we=1 every cycle; instr_count=10 after 10 RUN cycles.
REQ-031 branch_taken and jump_req in the same RUN cycle -> next_sel=3, ifreg_flush=1, then 1 FLUSH bubble, then RUN; bubble_count=2.
REQ-032 stall and jr_req together -> next_sel=2, pc_we=1 (redirect wins); stall alone for 3 cycles -> pc_we=0, ifreg_we=0, counters unchanged.
REQ-033 imem_ready low for 4 cycles -> WAIT_MEM, 5 bubble cycles, then RUN; a jump_req during the wait gives pc_we=1, next_sel=1 while remaining in WAIT_MEM.
REQ-034 halt -> HALTED, branch_taken ignored; resume -> RUN next cycle; rst pulse during HALTED -> BOOT with counters zeroed asynchronously.
REQ-035 Force instr_count to 0xFFFFFFFE, run 3 valid fetches -> reads 0xFFFFFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller: FSM states, fetch-mux
// selects and counter widths.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HALTED   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_PC4    = 2'd0;
  localparam logic [1:0] SEL_ADDR   = 2'd1;
  localparam logic [1:0] SEL_RS     = 2'd2;
  localparam logic [1:0] SEL_BRANCH = 2'd3;

  localparam int CNT_W = 32;
  localparam int SEQ_W = 8;

  // Redirect source priority: branch over jr over jump.
  function automatic logic [1:0] redir_sel(input logic br, input logic jr, input logic jmp);
    if (br)       return SEL_BRANCH;
    else if (jr)  return SEL_RS;
    else if (jmp) return SEL_ADDR;
    else          return SEL_PC4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter32.sv
// Saturating event counter with enable and asynchronous clear.
module sat_counter32
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC/fetch-register enables and the
// next-PC mux, inserting bubbles for boot, memory waits, redirects and halt.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int BOOT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        jump_req,
  input  logic        jr_req,
  input  logic        branch_taken,
  input  logic        halt,
  input  logic        resume,
  output logic [1:0]  next_sel,
  output logic        pc_we,
  output logic        ifreg_we,
  output logic        ifreg_flush,
  output logic        fetch_valid,
  output logic [2:0]  state,
  output logic [31:0] instr_count,
  output logic [31:0] bubble_count
);

  state_t           st, st_nx;
  logic [SEQ_W-1:0] boot_cnt, boot_nx;
  logic [SEQ_W-1:0] flush_cnt, flush_nx;
  logic             redir;
  logic [1:0]       rsel;

  assign redir = branch_taken | jr_req | jump_req;
  assign rsel  = redir_sel(branch_taken, jr_req, jump_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_BOOT;
      boot_cnt  <= SEQ_W'(BOOT_CYCLES);
      flush_cnt <= '0;
    end else begin
      st        <= st_nx;
      boot_cnt  <= boot_nx;
      flush_cnt <= flush_nx;
    end
  end

  always_comb begin
    st_nx       = st;
    boot_nx     = boot_cnt;
    flush_nx    = flush_cnt;
    pc_we       = 1'b0;
    ifreg_we    = 1'b0;
    ifreg_flush = 1'b0;
    next_sel    = SEL_PC4;
    case (st)
      ST_BOOT: begin
        ifreg_we    = 1'b1;
        ifreg_flush = 1'b1;
        if (boot_cnt <= SEQ_W'(1)) st_nx = ST_RUN;
        else                       boot_nx = boot_cnt - SEQ_W'(1);
      end
      ST_RUN: begin
        if (redir) begin
          pc_we       = 1'b1;
          next_sel    = rsel;
          ifreg_we    = 1'b1;
          ifreg_flush = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            st_nx    = ST_FLUSH;
            flush_nx = SEQ_W'(FLUSH_CYCLES);
          end
        end else if (stall) begin
          // hold PC and fetch register
        end else if (halt) begin
          ifreg_we    = 1'b1;
          ifreg_flush = 1'b1;
          st_nx       = ST_HALTED;
        end else if (!imem_ready) begin
          ifreg_we    = 1'b1;
          ifreg_flush = 1'b1;
          st_nx       = ST_WAIT_MEM;
        end else begin
          pc_we    = 1'b1;
          ifreg_we = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        ifreg_we    = 1'b1;
        ifreg_flush = 1'b1;
        // A redirect lands in the PC now; the fetch register stays a bubble.
        if (redir) begin
          pc_we    = 1'b1;
          next_sel = rsel;
        end
        if (imem_ready) st_nx = ST_RUN;
      end
      ST_FLUSH: begin
        ifreg_we    = 1'b1;
        ifreg_flush = 1'b1;
        if (redir) begin
          pc_we    = 1'b1;
          next_sel = rsel;
          flush_nx = SEQ_W'(FLUSH_CYCLES);
        end else if (flush_cnt <= SEQ_W'(1)) begin
          st_nx = ST_RUN;
        end else begin
          flush_nx = flush_cnt - SEQ_W'(1);
        end
      end
      ST_HALTED: begin
        ifreg_we    = 1'b1;
        ifreg_flush = 1'b1;
        if (resume) st_nx = ST_RUN;
      end
      default: st_nx = ST_BOOT;
    endcase
  end

  assign fetch_valid = ifreg_we & ~ifreg_flush;
  assign state       = st;

  sat_counter32 u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (fetch_valid),
    .count (instr_count)
  );

  sat_counter32 u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ifreg_flush & (st != ST_BOOT)),
    .count (bubble_count)
  );

endmodule
